// File: rtl/dds_pkg.sv
// Shared defaults, FSM state encoding and tone-table record for the DDS tone sequencer.
package dds_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned FW_DEF    = 32;
  localparam int unsigned DW_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  // One tone-table entry at the default widths; stored as {freq, dur}.
  typedef struct packed {
    logic [FW_DEF-1:0] freq;
    logic [DW_DEF-1:0] dur;
  } entry_t;

endpackage

// File: rtl/dds_tone_ram.sv
// Tone table: DEPTH x (FW+DW) register file, one synchronous write port, one combinational read port.
module dds_tone_ram
  import dds_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned FW    = FW_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [FW-1:0] wr_freq,
  input  logic [DW-1:0] wr_dur,
  input  logic [AW-1:0] rd_addr,
  output logic [FW-1:0] rd_freq_c,
  output logic [DW-1:0] rd_dur_c
);

  logic [FW+DW-1:0] mem [DEPTH];

  // Entry storage; cleared to freq=0/dur=0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= {wr_freq, wr_dur};
    end
  end

  assign {rd_freq_c, rd_dur_c} = mem[rd_addr];

endmodule

// File: rtl/dds_tone_seq.sv
// DDS tone sequencer: steps through a table of (frequency, duration) entries and drives a DDS.
module dds_tone_seq
  import dds_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned FW    = FW_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [FW-1:0] wr_freq,
  input  logic [DW-1:0] wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_idx,
  input  logic          tick,
  output logic [FW-1:0] freq_out,
  output logic          tone_en,
  output logic [AW-1:0] idx,
  output logic          busy,
  output logic          done
);

  state_e        state, state_nxt;
  logic [DW-1:0] remaining, remaining_nxt;
  logic [AW-1:0] idx_nxt;
  logic [FW-1:0] freq_nxt;
  logic          tone_en_nxt;
  logic          done_nxt;
  logic          adv;
  logic [FW-1:0] rd_freq_c;
  logic [DW-1:0] rd_dur_c;

  dds_tone_ram #(
    .DEPTH (DEPTH),
    .FW    (FW),
    .DW    (DW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_freq   (wr_freq),
    .wr_dur    (wr_dur),
    .rd_addr   (idx),
    .rd_freq_c (rd_freq_c),
    .rd_dur_c  (rd_dur_c)
  );

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    remaining_nxt = remaining;
    freq_nxt      = freq_out;
    tone_en_nxt   = tone_en;
    done_nxt      = 1'b0;
    adv           = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
        end
      end
      ST_LOAD: begin
        freq_nxt      = rd_freq_c;
        remaining_nxt = rd_dur_c;
        if (rd_dur_c != '0) begin
          state_nxt   = ST_PLAY;
          tone_en_nxt = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (remaining == DW'(1)) begin
            adv = 1'b1;
          end else begin
            remaining_nxt = remaining - DW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Leaving the current entry: next entry, wrap via loop, or finish.
    if (adv) begin
      tone_en_nxt   = 1'b0;
      remaining_nxt = '0;
      if (idx != last_idx) begin
        idx_nxt   = idx + AW'(1);
        state_nxt = ST_LOAD;
      end else if (loop) begin
        idx_nxt   = '0;
        state_nxt = ST_LOAD;
      end else begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
        freq_nxt  = '0;
      end
    end

    if (stop) begin
      state_nxt     = ST_IDLE;
      tone_en_nxt   = 1'b0;
      freq_nxt      = '0;
      remaining_nxt = '0;
      done_nxt      = 1'b0;
    end
  end

  // State, countdown and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      remaining <= '0;
      freq_out  <= '0;
      tone_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      remaining <= remaining_nxt;
      freq_out  <= freq_nxt;
      tone_en   <= tone_en_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dds_tone_seq.sv
// Self-checking bench for dds_tone_seq: cycle-vector table plus directed corner-case sequences.
module tb_dds_tone_seq;
  import dds_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned FW    = 32;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_freq;
  logic [DW-1:0] wr_dur;
  logic          start, stop, loop, tick;
  logic [AW-1:0] last_idx;
  logic [FW-1:0] freq_out;
  logic          tone_en;
  logic [AW-1:0] idx;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_ph  = 0;
  bit tick_auto = 0;

  typedef struct {
    bit start;
    bit stop;
    bit tick;
    bit lp;
    int reps;
    bit busy;
    bit ton;
    int idx;
    int freq;
    bit done;
  } vec_t;

  vec_t   vq[$];
  entry_t tbl[3];

  dds_tone_seq #(.DEPTH(DEPTH), .FW(FW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_freq  (wr_freq),
    .wr_dur   (wr_dur),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .last_idx (last_idx),
    .tick     (tick),
    .freq_out (freq_out),
    .tone_en  (tone_en),
    .idx      (idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic void add(bit s, bit sp, bit tk, bit lp, int reps,
                              bit b, bit t, int i, int f, bit d);
    vec_t v;
    v.start = s; v.stop = sp; v.tick = tk; v.lp = lp; v.reps = reps;
    v.busy = b; v.ton = t; v.idx = i; v.freq = f; v.done = d;
    vq.push_back(v);
  endfunction

  task automatic chk_int(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: returns #1 after the edge with tick set for the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tick_auto) begin
      tick_ph = (tick_ph + 1) % 4;
      tick = (tick_ph == 0);
    end else begin
      tick = 1'b0;
    end
  endtask

  task automatic wr(int a, int f, int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_freq = FW'(f); wr_dur = DW'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_tone(int want, int max_c, string nm);
    int c = 0;
    while (!(tone_en === 1'b1 && int'(idx) == want) && c < max_c) begin
      cyc();
      c++;
    end
    chk_int(nm, int'(tone_en === 1'b1 && int'(idx) == want), 1);
  endtask

  initial begin
    int ticks0, ticks2, tone_at1, saw1, dones, last_f, c, n, bad, tones, busy_seen;
    int fseq[$];
    bit fin;

    tbl[0] = '{freq: 32'd1000, dur: 16'd3};
    tbl[1] = '{freq: 32'd2000, dur: 16'd1};
    tbl[2] = '{freq: 32'd4000, dur: 16'd2};

    // Cycle vectors: same table, loop=0 then loop=1, tick every 4th cycle.
    for (int lp = 0; lp < 2; lp++) begin
      add(1, 0, 0, lp, 1, 1, 0, 0, 0,    0);
      add(0, 0, 0, lp, 2, 1, 1, 0, 1000, 0);
      add(0, 0, 1, lp, 1, 1, 1, 0, 1000, 0);
      add(0, 0, 0, lp, 3, 1, 1, 0, 1000, 0);
      add(0, 0, 1, lp, 1, 1, 1, 0, 1000, 0);
      add(0, 0, 0, lp, 3, 1, 1, 0, 1000, 0);
      add(0, 0, 1, lp, 1, 1, 0, 1, 1000, 0);
      add(0, 0, 0, lp, 3, 1, 1, 1, 2000, 0);
      add(0, 0, 1, lp, 1, 1, 0, 2, 2000, 0);
      add(0, 0, 0, lp, 3, 1, 1, 2, 4000, 0);
      add(0, 0, 1, lp, 1, 1, 1, 2, 4000, 0);
      add(0, 0, 0, lp, 3, 1, 1, 2, 4000, 0);
      if (lp == 0) begin
        add(0, 0, 1, 0, 1, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 2, 0, 0, 2, 0, 0);
      end else begin
        add(0, 0, 1, 1, 1, 1, 0, 0, 4000, 0);
        add(0, 0, 0, 1, 1, 1, 1, 0, 1000, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0, 0,    0);
        add(0, 0, 0, 1, 2, 0, 0, 0, 0,    0);
      end
    end

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; last_idx = 3'd2; tick = 1'b0;

    #12;
    chk_int("rst_freq_out", int'(freq_out), 0);
    chk_int("rst_flags", int'({tone_en, busy, done}), 0);
    chk_int("rst_idx", int'(idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    chk_int("post_rst_busy", int'(busy), 0);

    for (int i = 0; i < 3; i++) wr(i, int'(tbl[i].freq), int'(tbl[i].dur));

    foreach (vq[j]) begin
      for (int r = 0; r < vq[j].reps; r++) begin
        start = vq[j].start; stop = vq[j].stop; tick = vq[j].tick; loop = vq[j].lp;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== vq[j].busy || tone_en !== vq[j].ton || int'(idx) != vq[j].idx ||
            int'(freq_out) != vq[j].freq || done !== vq[j].done) begin
          n_fail++;
          $display("FAIL vec%0d.%0d: got busy=%b tone_en=%b idx=%0d freq=%0d done=%b, expected busy=%b tone_en=%b idx=%0d freq=%0d done=%b",
                   j, r, busy, tone_en, idx, freq_out, done,
                   vq[j].busy, vq[j].ton, vq[j].idx, vq[j].freq, vq[j].done);
        end
      end
    end
    start = 1'b0; stop = 1'b0; tick = 1'b0; loop = 1'b0;

    // Zero-duration entry 1 is skipped.
    tick_auto = 1; tick_ph = 0;
    wr(1, 2000, 0);
    start = 1'b1; cyc(); start = 1'b0;
    ticks0 = 0; ticks2 = 0; tone_at1 = 0; saw1 = 0; dones = 0; last_f = -1; fin = 0;
    for (int k = 0; k < 80 && !fin; k++) begin
      if (tone_en === 1'b1 && tick && idx == 3'd0) ticks0++;
      if (tone_en === 1'b1 && tick && idx == 3'd2) ticks2++;
      if (busy === 1'b1 && idx == 3'd1) saw1 = 1;
      if (tone_en === 1'b1 && idx == 3'd1) tone_at1++;
      if (tone_en === 1'b1 && int'(freq_out) != last_f) begin
        fseq.push_back(int'(freq_out));
        last_f = int'(freq_out);
      end
      if (done === 1'b1) begin
        dones++;
        fin = 1;
        chk_int("skip_done_freq", int'(freq_out), 0);
        chk_int("skip_done_busy", int'(busy), 0);
      end else begin
        cyc();
      end
    end
    chk_int("skip_done_seen", dones, 1);
    chk_int("skip_ticks_e0", ticks0, 3);
    chk_int("skip_ticks_e2", ticks2, 2);
    chk_int("skip_idx1_seen", saw1, 1);
    chk_int("skip_tone_at_idx1", tone_at1, 0);
    chk_int("skip_freq_count", fseq.size(), 2);
    chk_int("skip_freq0", (fseq.size() > 0) ? fseq[0] : -1, 1000);
    chk_int("skip_freq1", (fseq.size() > 1) ? fseq[1] : -1, 4000);
    cyc();
    chk_int("done_one_cycle", int'(done), 0);

    // Stop two ticks into entry 0.
    wr(1, 2000, 1);
    start = 1'b1; cyc(); start = 1'b0;
    wait_tone(0, 10, "stop_reach_play");
    c = 0;
    n = (tone_en === 1'b1 && tick) ? 1 : 0;
    while (n < 2 && c < 40) begin
      cyc();
      c++;
      if (tone_en === 1'b1 && tick) n++;
    end
    chk_int("stop_two_ticks", n, 2);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk_int("stop_busy", int'(busy), 0);
    chk_int("stop_tone_en", int'(tone_en), 0);
    chk_int("stop_freq_out", int'(freq_out), 0);
    dones = int'(done);
    for (int k = 0; k < 6; k++) begin cyc(); dones += int'(done); end
    chk_int("stop_no_done", dones, 0);

    // Rewrite the playing entry; change appears on the next loop pass.
    loop = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    wait_tone(0, 10, "wr_reach_play");
    wr(0, 7777, 3);
    bad = 0; c = 0;
    while (idx == 3'd0 && c < 40) begin
      if (tone_en === 1'b1 && int'(freq_out) != 1000) bad++;
      cyc();
      c++;
    end
    chk_int("wr_current_tone_kept", bad, 0);
    wait_tone(0, 80, "wr_loop_back");
    chk_int("wr_new_freq", int'(freq_out), 7777);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Asynchronous reset mid-play, then all-zero table skips through.
    loop = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    wait_tone(0, 10, "arst_reach_play");
    #3 rst_n = 1'b0;
    #1;
    chk_int("arst_freq_out", int'(freq_out), 0);
    chk_int("arst_flags", int'({tone_en, busy, done}), 0);
    chk_int("arst_idx", int'(idx), 0);
    tick = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_int("arst_no_done", int'(done), 0);
    start = 1'b1; cyc(); start = 1'b0;
    tones = 0; dones = 0; busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tones += int'(tone_en);
      dones += int'(done);
      busy_seen |= int'(busy);
      cyc();
    end
    chk_int("zero_tbl_no_tone", tones, 0);
    chk_int("zero_tbl_done", dones, 1);
    chk_int("zero_tbl_busy", busy_seen, 1);

    // All-zero table, loop through last_idx=DEPTH-1; start while busy is ignored.
    loop = 1'b1; last_idx = 3'd7;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk_int("zloop_idx", int'(idx), k % 8);
      chk_int("zloop_busy_tone", int'({busy, tone_en}), 2);
      start = (k == 3);
      cyc();
    end
    start = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    chk_int("zloop_stop_busy", int'(busy), 0);

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk_int("start_stop_busy", int'(busy), 0);
    cyc();
    chk_int("start_stop_busy2", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
